lzd_norm_pipe: RTL and testbench

- Parametrised, pipelined leading-zero detector and normaliser for the AWGN datapath.
- Feeds the log/sqrt range-reduction stages.
- Takes a WIDTH-bit unsigned operand, returns its leading-zero count and the operand left-shifted so the MSB is 1.
- Two register stages with valid/ready flow control; sustains one operand per clock when downstream is ready.

---
 rtl/lzd_norm_pipe.sv | 125 ++++++++++++
 tb/tb_lzd_norm_pipe.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lzd_norm_pipe.sv
// rtl/lzd_norm_pipe.sv - two-stage pipelined leading-zero detector and normaliser
// Optional macro LZD_ZERO_CNT_EN adds a saturating zero-operand counter.
module lzd_norm_pipe #(
    parameter int WIDTH = 32,
    localparam int CW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    out_lz,
    output logic [WIDTH-1:0] out_norm,
    output logic             out_zero
`ifdef LZD_ZERO_CNT_EN
    ,
    output logic [15:0]      zero_cnt
`endif
);

    localparam int NLEAF = WIDTH / 4;
    localparam int LV    = CW - 2;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_data;
    logic [CW-1:0]    s1_lz;
    logic             s1_zero;

    logic             s2_adv;
    logic             s1_adv;

    logic [CW-1:0]    tc [LV+1][NLEAF];
    logic             tv [LV+1][NLEAF];
    logic [3:0]       nib;
    logic [CW-1:0]    det_lz;
    logic             det_zero;
    logic [WIDTH-1:0] shifted;

    assign s2_adv   = out_ready | ~out_valid;
    assign s1_adv   = s2_adv | ~s1_valid;
    assign in_ready = s1_adv;

    // Tree of 4-bit detectors; an empty upper half adds its width to the lower count.
    always_comb begin
        nib = 4'd0;
        for (int l = 0; l <= LV; l++) begin
            for (int i = 0; i < NLEAF; i++) begin
                tc[l][i] = '0;
                tv[l][i] = 1'b0;
            end
        end
        for (int i = 0; i < NLEAF; i++) begin
            nib      = in_data[4*i +: 4];
            tv[0][i] = |nib;
            casez (nib)
                4'b1???: tc[0][i] = CW'(0);
                4'b01??: tc[0][i] = CW'(1);
                4'b001?: tc[0][i] = CW'(2);
                default: tc[0][i] = CW'(3);
            endcase
        end
        for (int l = 0; l < LV; l++) begin
            for (int j = 0; j < (NLEAF >> (l + 1)); j++) begin
                tv[l+1][j] = tv[l][2*j+1] | tv[l][2*j];
                tc[l+1][j] = tv[l][2*j+1] ? tc[l][2*j+1]
                                          : ((CW'(1) << (l + 2)) | tc[l][2*j]);
            end
        end
    end

    assign det_zero = ~tv[LV][0];
    assign det_lz   = tv[LV][0] ? tc[LV][0] : '0;

    always_comb begin
        shifted = s1_data;
        for (int k = 0; k < CW; k++) begin
            if (s1_lz[k]) begin
                shifted = shifted << (1 << k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_data   <= '0;
            s1_lz     <= '0;
            s1_zero   <= 1'b0;
            out_valid <= 1'b0;
            out_lz    <= '0;
            out_norm  <= '0;
            out_zero  <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_data <= in_data;
                    s1_lz   <= det_lz;
                    s1_zero <= det_zero;
                end
            end
            if (s2_adv) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_norm <= shifted;
                    out_lz   <= s1_lz;
                    out_zero <= s1_zero;
                end
            end
        end
    end

`ifdef LZD_ZERO_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            zero_cnt <= 16'd0;
        end else if (in_valid && in_ready && (in_data == '0) && (zero_cnt != 16'hFFFF)) begin
            zero_cnt <= zero_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lzd_norm_pipe.sv
// tb/tb_lzd_norm_pipe.sv - directed self-checking bench for lzd_norm_pipe (WIDTH=32)
module tb_lzd_norm_pipe;

    localparam int WIDTH = 32;
    localparam int CW    = 5;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [CW-1:0]    out_lz;
    logic [WIDTH-1:0] out_norm;
    logic             out_zero;
`ifdef LZD_ZERO_CNT_EN
    logic [15:0]      zero_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    lzd_norm_pipe #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_lz    (out_lz),
        .out_norm  (out_norm),
        .out_zero  (out_zero)
`ifdef LZD_ZERO_CNT_EN
        ,
        .zero_cnt  (zero_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [31:0] bb_data [4] = '{32'h80000000, 32'h00000001, 32'h00000000, 32'h0000F0F0};
    logic [4:0]  bb_lz   [4] = '{5'd0, 5'd31, 5'd0, 5'd16};
    logic [31:0] bb_norm [4] = '{32'h80000000, 32'h80000000, 32'h00000000, 32'hF0F00000};
    logic        bb_zero [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

    logic [31:0] bp_data [4] = '{32'h00000010, 32'h00300000, 32'h7FFFFFFF, 32'h00000003};
    logic [4:0]  bp_lz   [4] = '{5'd27, 5'd10, 5'd1, 5'd30};
    logic [31:0] bp_norm [4] = '{32'h80000000, 32'hC0000000, 32'hFFFFFFFE, 32'hC0000000};

    logic [4:0]  got_lz   [$];
    logic [31:0] got_norm [$];

    initial begin
        int idx_in;
        bit acc;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_lz",    out_lz,    0);
        chk("rst_out_norm",  out_norm,  0);
        chk("rst_out_zero",  out_zero,  0);
        chk("rst_in_ready",  in_ready,  1);

        // single operand
        in_valid = 1'b1;
        in_data  = 32'h00010000;
        tick();
        in_valid = 1'b0;
        chk("single_not_yet", out_valid, 0);
        tick();
        chk("single_valid", out_valid, 1);
        chk("single_lz",    out_lz,    15);
        chk("single_norm",  out_norm,  32'h80000000);
        chk("single_zero",  out_zero,  0);
        tick();
        chk("single_drained", out_valid, 0);

        // back-to-back stream
        for (int c = 0; c < 6; c++) begin
            if (c < 4) begin
                in_valid = 1'b1;
                in_data  = bb_data[c];
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (c >= 1 && c <= 4) begin
                chk($sformatf("bb_valid_%0d", c-1), out_valid, 1);
                chk($sformatf("bb_lz_%0d",    c-1), out_lz,    bb_lz[c-1]);
                chk($sformatf("bb_norm_%0d",  c-1), out_norm,  bb_norm[c-1]);
                chk($sformatf("bb_zero_%0d",  c-1), out_zero,  bb_zero[c-1]);
            end
        end
        chk("bb_drained", out_valid, 0);

        // backpressure
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = bp_data[0];
        tick();
        in_data   = bp_data[1];
        tick();
        chk("bp_first_valid", out_valid, 1);
        chk("bp_first_lz",    out_lz,    bp_lz[0]);
        out_ready = 1'b0;
        in_data   = bp_data[2];
        #1;
        chk("bp_in_ready_full", in_ready, 0);
        for (int s = 0; s < 3; s++) begin
            tick();
            chk($sformatf("bp_hold_valid_%0d", s), out_valid, 1);
            chk($sformatf("bp_hold_lz_%0d",    s), out_lz,    bp_lz[0]);
            chk($sformatf("bp_hold_norm_%0d",  s), out_norm,  bp_norm[0]);
            chk($sformatf("bp_hold_rdy_%0d",   s), in_ready,  0);
        end
        out_ready = 1'b1;
        idx_in    = 2;
        for (int b = 0; b < 20 && got_lz.size() < 4; b++) begin
            in_valid = (idx_in < 4);
            in_data  = (idx_in < 4) ? bp_data[idx_in] : 32'h0;
            #1;
            if (out_valid && out_ready) begin
                got_lz.push_back(out_lz);
                got_norm.push_back(out_norm);
            end
            acc = in_valid && in_ready;
            tick();
            if (acc) idx_in++;
        end
        in_valid = 1'b0;
        chk("bp_count", got_lz.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("bp_lz_%0d",   i), (i < got_lz.size())   ? got_lz[i]   : 5'h1F,  bp_lz[i]);
            chk($sformatf("bp_norm_%0d", i), (i < got_norm.size()) ? got_norm[i] : 32'h0,  bp_norm[i]);
        end
        #1;
        chk("bp_drained", out_valid, 0);

        // bubbles: in_valid 1,0,1
        in_valid = 1'b1;
        in_data  = 32'h00000800;
        tick();
        in_valid = 1'b0;
        tick();
        chk("bub_v0", out_valid, 1);
        chk("bub_lz0", out_lz, 20);
        in_valid = 1'b1;
        in_data  = 32'h01000000;
        tick();
        chk("bub_v1", out_valid, 0);
        in_valid = 1'b0;
        tick();
        chk("bub_v2", out_valid, 1);
        chk("bub_lz2", out_lz, 7);
        chk("bub_norm2", out_norm, 32'h80000000);

        // reset with both stages full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h00000001;
        tick();
        in_data   = 32'h00000002;
        tick();
        #1;
        chk("mid_full_rdy", in_ready, 0);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_rdy",   in_ready,  1);
        chk("mid_rst_lz",    out_lz,    0);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h00000100;
        tick();
        in_valid = 1'b0;
        chk("mid_no_ghost", out_valid, 0);
        tick();
        chk("mid_after_valid", out_valid, 1);
        chk("mid_after_lz",    out_lz,    23);
        chk("mid_after_norm",  out_norm,  32'h80000000);
        tick();
        chk("mid_after_drain", out_valid, 0);

`ifdef LZD_ZERO_CNT_EN
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("zc_reset", zero_cnt, 0);
        in_valid = 1'b1;
        in_data = 32'h0;        tick();
        in_data = 32'h5;        tick();
        in_data = 32'h0;        tick();
        in_data = 32'h7;        tick();
        in_data = 32'h0;        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("zc_three", zero_cnt, 3);

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'h0;
        repeat (65534) tick();
        in_valid = 1'b0;
        tick();
        chk("zc_preload", zero_cnt, 16'hFFFE);
        in_valid = 1'b1;
        repeat (3) tick();
        in_valid = 1'b0;
        tick();
        chk("zc_saturate", zero_cnt, 16'hFFFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
